// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its single-bit cal slice.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;

    localparam logic [1:0] CL_AND  = 2'b00;
    localparam logic [1:0] CL_OR   = 2'b01;
    localparam logic [1:0] CL_XOR  = 2'b10;
    localparam logic [1:0] CL_NOTA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_seq_cal.sv
// Single-bit ALU slice: full adder plus a 4-function logic unit, selected by l.
module cal
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic       l,
    input  logic [1:0] s,
    output logic       out,
    output logic       c_out
);

    logic sum;
    logic lu;

    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
        case (s)
            CL_AND:  lu = a & b;
            CL_OR:   lu = a | b;
            CL_XOR:  lu = a ^ b;
            default: lu = ~a;
        endcase
        out = l ? sum : lu;
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds cal one bit per cycle, LSB first, and assembles the result.
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero,
    output logic         err
);

    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           zero_q, zero_d;
    logic           err_q, err_d;

    logic           dec_l, dec_sub;
    logic [1:0]     dec_s;
    logic           cal_out, cal_cout;
    logic [W-1:0]   res_sh;

    always_comb begin
        dec_l   = 1'b0;
        dec_sub = 1'b0;
        dec_s   = CL_AND;
        case (op_q)
            OP_ADD:  dec_l = 1'b1;
            OP_SUB:  begin dec_l = 1'b1; dec_sub = 1'b1; end
            OP_AND:  dec_s = CL_AND;
            OP_OR:   dec_s = CL_OR;
            OP_XOR:  dec_s = CL_XOR;
            OP_NOTA: dec_s = CL_NOTA;
            default: dec_s = CL_AND;
        endcase
    end

    cal u_cal (
        .a     (a_q[0]),
        .b     (b_q[0] ^ dec_sub),
        .c_in  (carry_q),
        .l     (dec_l),
        .s     (dec_s),
        .out   (cal_out),
        .c_out (cal_cout)
    );

    // New bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
    assign res_sh = (res_q >> 1) | (W'(cal_out) << (W - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    res_d   = '0;
                    carry_d = (op == OP_SUB);
                    cout_d  = 1'b0;
                    zero_d  = 1'b0;
                    err_d   = (op == OP_RSV0) || (op == OP_RSV1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Reserved opcodes pass through here for a single cycle with the result held at 0.
                if (err_q) begin
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    res_d   = res_sh;
                    carry_d = dec_l ? cal_cout : carry_q;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        cout_d  = dec_l & cal_cout;
                        zero_d  = (res_sh == '0);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign result      = res_q;
    assign carry_out   = cout_q;
    assign zero        = zero_q;
    assign err         = err_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq: arithmetic reference model, decoupled result monitor.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         res_ready = 1'b1;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         start_ready, res_valid, carry_out, zero, err;
    logic [W-1:0] result;

    serial_alu_seq #(.W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .zero        (zero),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         e;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;
    logic rr_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sum;
        e.c = 1'b0; e.e = 1'b0; e.lat = W; e.acc = 0;
        sum = int'(x) + int'(y);
        case (o)
            3'd0: begin e.r = W'(sum); e.c = (sum >= (1 << W)); end
            3'd1: begin e.r = x - y;   e.c = (x >= y); end
            3'd2: e.r = x & y;
            3'd3: e.r = x | y;
            3'd4: e.r = x ^ y;
            3'd5: e.r = ~x;
            default: begin e.r = '0; e.e = 1'b1; e.lat = 1; end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Called in the posedge+1 phase; returns in that phase after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   n = 0;
        while (!start_ready && n < 300) begin
            if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!start_ready) begin
            n_chk++;
            $display("FAIL issue_wait: start_ready=%0b required 1", start_ready);
            return;
        end
        start_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        e = model(o, x, y);
        e.acc = cyc;
        sb.push_back(e);
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !start_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            $display("FAIL drain: pending=%0d required 0", sb.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_res_valid"},   res_valid,   0);
        chk({tag, "_result"},      result,      0);
        chk({tag, "_carry_out"},   carry_out,   0);
        chk({tag, "_zero"},        zero,        0);
        chk({tag, "_err"},         err,         0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v <= 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: res_valid=1 with nothing outstanding");
                end else begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                end
            end
            if (res_valid && res_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("result",    result,    mon_e.r);
                chk("carry_out", carry_out, mon_e.c);
                chk("zero",      zero,      mon_e.z);
                chk("err",       err,       mon_e.e);
            end
            prev_v <= res_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        exp_t bp;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 8'hFF, 8'h01);
        issue(3'd1, 8'h05, 8'h07);
        issue(3'd1, 8'h07, 8'h05);
        issue(3'd4, 8'hA5, 8'h0F);
        issue(3'd5, 8'h3C, 8'h99);
        issue(3'd2, 8'hF0, 8'h3C);
        issue(3'd6, 8'h12, 8'h34);
        issue(3'd0, 8'h10, 8'h20);
        issue(3'd7, 8'hFF, 8'hFF);
        issue(3'd1, 8'h80, 8'h80);
        drain();

        // Backpressure with a competing offer held high in DONE.
        res_ready = 1'b0;
        issue(3'd0, 8'h40, 8'hC1);
        bp = model(3'd0, 8'h40, 8'hC1);
        n = 0;
        while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_reach_done", res_valid, 1);
        start_valid = 1'b1; op = 3'd4; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_result", result, bp.r);
            chk("bp_carry", carry_out, bp.c);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_res_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", start_ready, 1);
        chk("bp_idle_valid", res_valid, 0);
        @(posedge clk); #1;
        bp = model(3'd4, 8'h11, 8'h22);
        bp.acc = cyc;
        sb.push_back(bp);
        start_valid = 1'b0;
        chk("bp_accepted", start_ready, 0);
        drain();

        // Reset in the 3rd RUN cycle aborts the operation.
        issue(3'd0, 8'h12, 8'h34);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk_reset_vals("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        issue(3'd0, 8'h01, 8'h01);
        drain();

        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        rr_rand = 1'b0;
        res_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
